// File: rtl/ipsl_hmic_h_ddrphy_training_pkg.sv
// Shared types and helpers for the HMIC DDR PHY DQS reset-training controller.
// The parameter-range macro expands to an elaboration-time check inside a generate region.

`ifndef HMIC_PARAM_RANGE
`define HMIC_PARAM_RANGE(name, val, lo, hi) \
   if ((int'(val) < int'(lo)) || (int'(val) > int'(hi))) begin : name \
      $error("ipsl_hmic_h_ddrphy_training: parameter out of range"); \
   end
`endif

package ipsl_hmic_h_ddrphy_training_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAssert = 2'd1,
      StSettle = 2'd2,
      StAck    = 2'd3
   } train_state_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ipsl_hmic_h_ddrphy_req_sync.sv
// Per-lane request synchroniser with a rising-edge detector on the synchronised level.

module ipsl_hmic_h_ddrphy_req_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req_async,
   output logic req_edge
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign req_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ipsl_hmic_h_ddrphy_training_ctrl_v1_2.sv
// Multi-lane DQS reset-training controller: pulses srb_dqs_rst_training per requested lane,
// waits a settle time, then acknowledges. Simultaneous or round-robin serial operation.

module ipsl_hmic_h_ddrphy_training_ctrl_v1_2
   import ipsl_hmic_h_ddrphy_training_pkg::*;
#(
   parameter int unsigned LANE_NUM     = 4,
   parameter int unsigned RST_HIGH_CLK = 4,
   parameter int unsigned SETTLE_CLK   = 0,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned SERIAL_MODE  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ddrphy_in_rst,
   input  logic [LANE_NUM-1:0] ddrphy_rst_req,
   output logic [LANE_NUM-1:0] srb_dqs_rst_training,
   output logic [LANE_NUM-1:0] ddrphy_rst_ack,
   output logic                busy,
   output logic                req_merged
);

   `HMIC_PARAM_RANGE(gen_bad_lane_num, LANE_NUM, 1, 16)
   `HMIC_PARAM_RANGE(gen_bad_rst_high_clk, RST_HIGH_CLK, 1, 255)
   `HMIC_PARAM_RANGE(gen_bad_settle_clk, SETTLE_CLK, 0, 255)
   `HMIC_PARAM_RANGE(gen_bad_sync_stages, SYNC_STAGES, 2, 4)
   `HMIC_PARAM_RANGE(gen_bad_serial_mode, SERIAL_MODE, 0, 1)

   localparam int unsigned CNT_MAX = (RST_HIGH_CLK > SETTLE_CLK) ? RST_HIGH_CLK : SETTLE_CLK;
   localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
   localparam int unsigned PTR_W   = (LANE_NUM > 1) ? clog2(LANE_NUM) : 1;

   localparam logic [CNT_W-1:0] CNT_ASSERT = CNT_W'(RST_HIGH_CLK);
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CLK);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [LANE_NUM-1:0] req_edge;

   for (genvar i = 0; i < LANE_NUM; i++) begin : gen_lane
      ipsl_hmic_h_ddrphy_req_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk      (clk),
         .rst      (rst),
         .req_async(ddrphy_rst_req[i]),
         .req_edge (req_edge[i])
      );
   end

   train_state_e        state_q, state_d;
   logic [LANE_NUM-1:0] pending_q, pending_d;
   logic [LANE_NUM-1:0] sel_q, sel_d;
   logic [LANE_NUM-1:0] clr;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LANE_NUM-1:0] srb_q, srb_d;
   logic [LANE_NUM-1:0] ack_q, ack_d;
   logic                merged_q, merged_d;

   // Round-robin pick: first pending lane at or above rr_ptr, wrapping.
   logic [LANE_NUM-1:0] rr_sel;
   logic [PTR_W-1:0]    rr_next;
   logic                rr_found;
   int unsigned         rr_idx;

   always_comb begin
      rr_sel   = '0;
      rr_next  = rr_ptr_q;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int unsigned k = 0; k < LANE_NUM; k++) begin
         rr_idx = (32'(rr_ptr_q) + k) % LANE_NUM;
         if (!rr_found && pending_q[rr_idx]) begin
            rr_found        = 1'b1;
            rr_sel[rr_idx]  = 1'b1;
            rr_next         = PTR_W'((rr_idx + 1) % LANE_NUM);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      clr      = '0;
      case (state_q)
         StIdle: begin
            if (pending_q != '0) begin
               if (SERIAL_MODE == 0) begin
                  sel_d = pending_q;
               end else begin
                  sel_d    = rr_sel;
                  rr_ptr_d = rr_next;
               end
               clr     = sel_d;
               cnt_d   = CNT_ASSERT;
               state_d = StAssert;
            end
         end
         StAssert: begin
            if (cnt_q == CNT_ONE) begin
               if (SETTLE_CLK == 0) begin
                  state_d = StAck;
               end else begin
                  cnt_d   = CNT_SETTLE;
                  state_d = StSettle;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         StSettle: begin
            if (cnt_q == CNT_ONE) state_d = StAck;
            else                  cnt_d   = cnt_q - CNT_ONE;
         end
         StAck: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Global PHY reset aborts everything; the aborted lanes get no ack.
      if (ddrphy_in_rst) begin
         state_d = StIdle;
         sel_d   = '0;
         cnt_d   = '0;
      end

      pending_d = ddrphy_in_rst ? '0 : ((pending_q & ~clr) | req_edge);
      srb_d     = ddrphy_in_rst ? '1 : ((state_d == StAssert) ? sel_d : '0);
      ack_d     = (state_d == StAck) ? sel_d : '0;
      merged_d  = |(req_edge & (pending_q | ((state_q != StIdle) ? sel_q : '0)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         srb_q     <= '1;
         ack_q     <= '0;
         merged_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         // sel only lives until the ack has been issued.
         sel_q     <= (state_q == StAck) ? '0 : sel_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         srb_q     <= srb_d;
         ack_q     <= ack_d;
         merged_q  <= merged_d;
      end
   end

   assign srb_dqs_rst_training = srb_q;
   assign ddrphy_rst_ack       = ack_q;
   assign req_merged           = merged_q;
   assign busy                 = (state_q != StIdle) || (pending_q != '0);

endmodule
